// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared constants for the instruction-fetch stage: the bubble encoding, the
// 1-bit FETCH/HOLD state encoding, the PC increment and a word-align helper.
// -----------------------------------------------------------------------------
package if_stage_pkg;

  // sll $0,$0,0 -- the canonical MIPS no-op used as an IF/ID bubble.
  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

  // Sequential instruction stride in bytes.
  localparam logic [31:0] PC_INC = 32'd4;

  // FETCH: a request is outstanding at pc.
  // HOLD : an instruction arrived during a stall and sits in the hold buffer.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetchState_t;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// -----------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register. Flush beats load, load beats hold.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high; loads the bubble
//   load        in   capture {instr, pcPlus4} as a valid instruction
//   flush       in   replace contents with a bubble (priority over load/hold)
//   instr       in   instruction to capture
//   pcPlus4     in   PC+4 of that instruction
//   ifidInstr   out  registered instruction
//   ifidPcPlus4 out  registered PC+4
//   ifidValid   out  1 = register holds a real instruction
// -----------------------------------------------------------------------------
import if_stage_pkg::*;

module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pcPlus4,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPcPlus4,
  output logic        ifidValid
);

  always_ff @(posedge clock) begin
    // NOTE: registers are assigned with <= so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (reset || flush) begin
      ifidInstr   <= NOP_INSTR;
      ifidPcPlus4 <= '0;
      ifidValid   <= 1'b0;
    end else if (load) begin
      ifidInstr   <= instr;
      ifidPcPlus4 <= pcPlus4;
      ifidValid   <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage with IF/ID register. Holds the PC, issues fetches,
// obeys the hazard unit's PCWrite/IFIDWrite stalls, applies EX/MEM branch
// redirects, and keeps an instruction that returns during a stall in a
// one-entry hold buffer so it is never fetched twice.
//
// Build option: define IF_STAGE_FETCH_CNT_EN to get a saturating count of
// valid IF/ID loads on fetch_cnt; otherwise fetch_cnt is tied to zero.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high
//   pc_write       in   PCWrite from hazard unit (0 = hold PC)
//   ifid_write     in   IFIDWrite from hazard unit (0 = hold IF/ID)
//   branch_taken   in   resolved taken branch from EX/MEM
//   branch_target  in   redirect address (low two bits ignored)
//   imem_req       out  fetch request, high only in FETCH
//   imem_addr      out  fetch address, always equal to pc
//   imem_instr     in   returned instruction, valid with imem_rdy
//   imem_rdy       in   memory returns data for imem_addr this cycle
//   pc             out  current fetch PC
//   ifid_instr     out  IF/ID instruction
//   ifid_pc_plus4  out  IF/ID PC+4
//   ifid_valid     out  IF/ID holds a real instruction
//   fetch_cnt      out  valid-fetch counter (optional)
// -----------------------------------------------------------------------------
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_rdy,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] fetch_cnt
);

  fetchState_t state, stateNext;
  logic [31:0] pcReg, pcNext, pcPlus4;
  logic [31:0] holdBuf, holdBufNext;
  logic [31:0] loadInstr;
  logic        stall, load, flush;

  // A half-stall (only one of the two enables low) is treated as a full
  // stall so the PC and IF/ID can never drift apart.
  assign stall   = ~ifid_write | ~pc_write;
  assign pcPlus4 = pcReg + PC_INC;  // modulo 2^32, wraps silently

  assign imem_req  = (state == FETCH);
  assign imem_addr = pcReg;
  assign pc        = pcReg;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    stateNext   = state;
    pcNext      = pcReg;
    holdBufNext = holdBuf;
    loadInstr   = imem_instr;
    load        = 1'b0;
    flush       = 1'b0;

    if (branch_taken) begin
      // Redirect wins over stall and imem_rdy; any returning data is dropped.
      pcNext      = alignWord(branch_target);
      stateNext   = FETCH;
      holdBufNext = '0;
      flush       = 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_rdy && !stall) begin
            load   = 1'b1;
            pcNext = pcPlus4;
          end else if (imem_rdy) begin
            // Data arrived while stalled: park it instead of re-fetching.
            holdBufNext = imem_instr;
            stateNext   = HOLD;
          end else if (!stall) begin
            flush = 1'b1;  // memory not ready: push a bubble
          end
        end
        HOLD: begin
          if (!stall) begin
            load      = 1'b1;
            loadInstr = holdBuf;
            pcNext    = pcPlus4;
            stateNext = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH;
      pcReg   <= RESET_PC;
      holdBuf <= '0;
    end else begin
      state   <= stateNext;
      pcReg   <= pcNext;
      holdBuf <= holdBufNext;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .flush       (flush),
    .instr       (loadInstr),
    .pcPlus4     (pcPlus4),
    .ifidInstr   (ifid_instr),
    .ifidPcPlus4 (ifid_pc_plus4),
    .ifidValid   (ifid_valid)
  );

`ifdef IF_STAGE_FETCH_CNT_EN
  logic [31:0] fetchCnt;

  // Counts only valid IF/ID loads; bubbles and flushes never set load.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetchCnt <= '0;
    end else if (load && (fetchCnt != '1)) begin
      fetchCnt <= fetchCnt + 32'd1;
    end
  end

  assign fetch_cnt = fetchCnt;
`else
  assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage: a behavioural model of the fetch stage is
// compared against the DUT on every falling edge, and directed steps pin the
// model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_write, ifid_write, branch_taken, imem_rdy;
  logic [31:0] branch_target, imem_instr;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, pc, ifid_instr, ifid_pc_plus4, fetch_cnt;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

`ifdef IF_STAGE_FETCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .imem_rdy      (imem_rdy),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .fetch_cnt     (fetch_cnt)
  );

  // Instruction memory contents: a few real instructions, then a unique
  // address-derived word everywhere else.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C01_0000;
      32'h0000_0004: return 32'h0022_1820;
      32'h0000_0008: return 32'h8C03_0004;
      default:       return 32'h2400_0000 | (a & 32'h0000_FFFF);
    endcase
  endfunction

  assign imem_instr = memWord(imem_addr);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mPc, mHeld, mInstr, mPcPlus4, mCnt;
  logic        mHolding, mValid;
  logic        tbStall;
  assign tbStall = !pc_write || !ifid_write;

  always @(posedge clock) begin
    if (reset) begin
      mPc <= 32'h0; mHolding <= 1'b0; mHeld <= 32'h0;
      mInstr <= 32'h0; mPcPlus4 <= 32'h0; mValid <= 1'b0; mCnt <= 32'h0;
    end else if (branch_taken) begin
      mPc <= branch_target & 32'hFFFF_FFFC;
      mHolding <= 1'b0;
      mInstr <= 32'h0; mPcPlus4 <= 32'h0; mValid <= 1'b0;
    end else if (tbStall) begin
      if (!mHolding && imem_rdy) begin
        mHolding <= 1'b1;
        mHeld    <= memWord(mPc);
      end
    end else if (mHolding || imem_rdy) begin
      mInstr   <= mHolding ? mHeld : memWord(mPc);
      mPcPlus4 <= mPc + 32'd4;
      mPc      <= mPc + 32'd4;
      mValid   <= 1'b1;
      mHolding <= 1'b0;
      if (CNT_EN && mCnt != 32'hFFFF_FFFF) mCnt <= mCnt + 32'd1;
    end else begin
      mInstr <= 32'h0; mPcPlus4 <= 32'h0; mValid <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (checkEn) begin
      check("pc",            pc,              mPc);
      check("imem_addr",     imem_addr,       mPc);
      check("imem_req",      {31'b0, imem_req},   {31'b0, !mHolding});
      check("ifid_instr",    ifid_instr,      mInstr);
      check("ifid_pc_plus4", ifid_pc_plus4,   mPcPlus4);
      check("ifid_valid",    {31'b0, ifid_valid}, {31'b0, mValid});
      check("fetch_cnt",     fetch_cnt,       mCnt);
    end
  end

  // One clock edge with the current inputs, then sit just after the falling edge.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic pw, input logic iw, input logic rdy,
                       input logic br, input logic [31:0] tgt);
    pc_write = pw; ifid_write = iw; imem_rdy = rdy;
    branch_taken = br; branch_target = tgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(1, 1, 1, 0, 32'h0);
    tick();
    checkEn = 1'b1;
    check("rst_pc",    pc,                  32'h0);
    check("rst_valid", {31'b0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instr,          32'h0);
    check("rst_req",   {31'b0, imem_req},   32'h1);

    // Straight-line fetch.
    reset = 1'b0;
    tick();
    check("tp1_instr0", ifid_instr,    32'h8C01_0000);
    check("tp1_pc4_0",  ifid_pc_plus4, 32'h4);
    tick();
    check("tp1_instr1", ifid_instr,    32'h0022_1820);
    check("tp1_pc4_1",  ifid_pc_plus4, 32'h8);
    check("tp1_pc",     pc,            32'h8);

    // Load-use stall with data returning at pc=8.
    drive(0, 0, 1, 0, 32'h0);
    tick();
    check("tp2_req",   {31'b0, imem_req}, 32'h0);
    check("tp2_instr", ifid_instr,        32'h0022_1820);
    check("tp2_pc",    pc,                32'h8);
    // Release with memory idle: data must come from the hold buffer.
    drive(1, 1, 0, 0, 32'h0);
    tick();
    check("tp2_held",  ifid_instr,        32'h8C03_0004);
    check("tp2_pc4",   ifid_pc_plus4,     32'hC);
    check("tp2_valid", {31'b0, ifid_valid}, 32'h1);

    // Half-stall parks the instruction at 12; stay parked one more cycle.
    drive(1, 0, 1, 0, 32'h0);
    tick();
    check("half_req", {31'b0, imem_req}, 32'h0);
    drive(0, 0, 1, 0, 32'h0);
    tick();
    // Redirect while in HOLD; low target bits ignored.
    drive(0, 0, 1, 1, 32'h0000_0043);
    tick();
    check("tp3_pc",    pc,                  32'h40);
    check("tp3_valid", {31'b0, ifid_valid}, 32'h0);
    check("tp3_instr", ifid_instr,          32'h0);
    check("tp3_req",   {31'b0, imem_req},   32'h1);
    drive(1, 1, 1, 0, 32'h0);
    tick();
    check("tp3_after", ifid_instr, 32'h2400_0040);
    check("tp3_pc4",   ifid_pc_plus4, 32'h44);

    // Memory not ready for three cycles: bubbles, PC stable.
    drive(1, 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tp4_valid", {31'b0, ifid_valid}, 32'h0);
      check("tp4_addr",  imem_addr,           32'h44);
    end

    // Redirect with data returning the same cycle: data dropped.
    drive(1, 1, 1, 1, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc0",  pc,                  32'hFFFF_FFFC);
    check("drop_valid", {31'b0, ifid_valid}, 32'h0);
    drive(1, 1, 1, 0, 32'h0);
    tick();
    check("wrap_pc",   pc,            32'h0);
    check("wrap_pc4",  ifid_pc_plus4, 32'h0);
    check("wrap_instr", ifid_instr,   32'h2400_FFFC);
    check("cnt5", fetch_cnt, CNT_EN ? 32'd5 : 32'd0);

    // Park an instruction, then reset in the middle of HOLD.
    drive(0, 0, 1, 0, 32'h0);
    tick();
    check("pre_rst_req", {31'b0, imem_req}, 32'h0);
    reset = 1'b1;
    tick();
    check("tp5_pc",    pc,                  32'h0);
    check("tp5_valid", {31'b0, ifid_valid}, 32'h0);
    check("tp5_instr", ifid_instr,          32'h0);
    check("tp5_pc4",   ifid_pc_plus4,       32'h0);
    check("tp5_req",   {31'b0, imem_req},   32'h1);
    check("tp5_cnt",   fetch_cnt,           32'h0);
    reset = 1'b0;

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 80; i++) begin
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0),
            32'($urandom));
      tick();
    end

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
